// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one combinational-read memory between a fetch port and a load/store port
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise LSU wins every tie.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req_valid/ready, if_addr   read-only fetch request
//   if_resp_valid, if_rdata       fetch response, rdata held until the next fetch response
//   lsu_req_valid/ready, lsu_*    load/store request with write enable and byte mask
//   lsu_resp_valid, lsu_rdata     load/store response, rdata held until the next LSU response
//   mem_valid/addr/wdata/wen/wmask, mem_rdata   shared memory port
module mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic              lsu_wen,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic [7:0]        mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_if_rdata, r_lsu_rdata;
    logic              r_wen, r_owner_lsu;
    logic [7:0]        r_wmask;
    logic              w_sel_lsu, w_hs, w_busy;
`ifdef MEM_ARB_RR_EN
    logic              r_last_lsu;
    // on a tie the port that lost last time wins
    assign w_sel_lsu = lsu_req_valid && (!if_req_valid || !r_last_lsu);
`else
    assign w_sel_lsu = lsu_req_valid;
`endif
    always_comb begin
        w_busy         = r_state == BUSY;
        if_req_ready   = r_state == IDLE && if_req_valid && !w_sel_lsu;
        lsu_req_ready  = r_state == IDLE && w_sel_lsu;
        // ready is only raised towards a valid requester, so any ready is a handshake
        w_hs           = if_req_ready || lsu_req_ready;
        w_next         = r_state == IDLE ? (w_hs ? BUSY : IDLE) :
                         w_busy ? (r_cnt == 4'd0 ? RESP : BUSY) : IDLE;
        mem_valid      = w_busy;
        mem_addr       = w_busy ? r_addr : '0;
        mem_wdata      = w_busy ? r_wdata : '0;
        mem_wmask      = w_busy ? r_wmask : 8'h00;
        // the write strobe fires once, in the last access cycle
        mem_wen        = w_busy && r_cnt == 4'd0 && r_wen;
        if_resp_valid  = r_state == RESP && !r_owner_lsu;
        lsu_resp_valid = r_state == RESP && r_owner_lsu;
        if_rdata       = r_if_rdata;
        lsu_rdata      = r_lsu_rdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wen       <= 1'b0;
            r_wmask     <= 8'h00;
            r_owner_lsu <= 1'b0;
            r_if_rdata  <= '0;
            r_lsu_rdata <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_lsu  <= 1'b1;
`endif
        end else begin
            r_state <= w_next;
            if (w_hs) begin
                r_cnt       <= 4'(LATENCY - 1);
                r_owner_lsu <= lsu_req_ready;
                r_addr      <= lsu_req_ready ? lsu_addr : if_addr;
                r_wdata     <= lsu_req_ready ? lsu_wdata : '0;
                r_wen       <= lsu_req_ready && lsu_wen;
                r_wmask     <= lsu_req_ready ? lsu_wmask : 8'hff;
`ifdef MEM_ARB_RR_EN
                r_last_lsu  <= lsu_req_ready;
`endif
            end else if (w_busy && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end else if (w_busy) begin
                if (r_owner_lsu) r_lsu_rdata <= mem_rdata;
                else r_if_rdata <= mem_rdata;
            end
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width.
REQ-003 SHALL have parameter LATENCY, default 1, memory access cycles (legal range 1..15).
REQ-004 SHALL have ports: clk  in  1  single clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: if_req_valid  in  1; if_req_ready  out  1; if_addr  in  ADDR_W; if_resp_valid  out  1; if_rdata  out  DATA_W (fetch port, read-only).
REQ-006 SHALL have ports: lsu_req_valid  in  1; lsu_req_ready  out  1; lsu_addr  in  ADDR_W; lsu_wdata  in  DATA_W; lsu_wen  in  1; lsu_wmask  in  8; lsu_resp_valid  out  1; lsu_rdata  out  DATA_W.
REQ-007 SHALL have ports: mem_valid  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_wen  out  1; mem_wmask  out  8; mem_rdata  in  DATA_W (combinational-read memory).

Function
REQ-008 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-009 In IDLE, SHALL assert req_ready combinationally only to the selected requester; the other port's ready SHALL be 0.
REQ-010 Handshake = valid & ready on a rising clk; on handshake SHALL latch addr, wdata, wen, wmask, owner, and go to BUSY with counter = LATENCY-1.
REQ-011 IF requests SHALL be latched with wen=0, wmask=8'hff.
REQ-012 In BUSY, SHALL drive mem_valid=1 with latched addr/wdata/wmask; counter decrements each cycle.
REQ-013 mem_wen SHALL be 1 only in the BUSY cycle with counter==0 and latched wen=1; 0 otherwise.
REQ-014 At counter==0 in BUSY, SHALL capture mem_rdata into the owner's rdata register and go to RESP.
REQ-015 In RESP, SHALL assert owner's resp_valid for exactly one cycle, then return to IDLE; both ready signals SHALL be 0 in BUSY and RESP.
REQ-016 Latency: handshake at cycle T -> resp_valid at cycle T+LATENCY+1; next handshake no earlier than T+LATENCY+2.
REQ-017 Write responses SHALL also assert resp_valid; rdata for writes SHALL be the mem_rdata sampled that cycle.
REQ-018 if_rdata/lsu_rdata SHALL hold their last captured value until overwritten by that port's next response.
REQ-019 In IDLE and RESP, mem_valid, mem_wen SHALL be 0 and mem_addr, mem_wdata, mem_wmask SHALL be 0.
REQ-020 Requests dropped before handshake SHALL not be serviced; a requester may change addr freely until handshake.
REQ-021 Grant decision SHALL use only valid inputs of the current IDLE cycle; no request is queued.

Reset
REQ-022 On rst high at a clock edge: state=IDLE, counter=0, if_rdata=0, lsu_rdata=0, resp_valid both 0, last-grant=LSU.
REQ-023 Reset during BUSY SHALL abort the transaction: no resp_valid issued, mem_wen 0 from the next cycle.
REQ-024 rst SHALL dominate a simultaneous handshake; no request is accepted in the reset cycle.

Configuration
REQ-025 Macro MEM_ARB_RR_EN: defined -> round-robin; when both valid in IDLE, grant goes to the port not granted last; last-grant updates on each handshake.
REQ-026 Without MEM_ARB_RR_EN: fixed priority, LSU always wins ties; last-grant register absent.

Verification
REQ-027 LATENCY=1, IF valid alone, addr 0x80000000, mem_rdata 0x00000013 -> if_resp_valid at T+2, if_rdata=0x13, lsu_resp_valid stays 0.
REQ-028 LATENCY=3, LSU write addr 0x80001000 wdata 0xdeadbeef wmask 0x0f -> mem_wen high exactly at T+3, lsu_resp_valid at T+4.
REQ-029 Both valid continuously, no macro -> LSU granted every time, if_req_ready never 1.
REQ-030 Both valid continuously, MEM_ARB_RR_EN -> grants alternate IF, LSU, IF, ... (first IF after reset).
REQ-031 LATENCY=4, rst asserted at T+2 of LSU write -> mem_wen never 1, no resp_valid, ready returns in IDLE after reset.
REQ-032 Back-to-back IF reads, LATENCY=2 -> handshakes spaced 4 cycles, responses at T+3, T+7.
